// File: rtl/pe_matmul2x2_seq.sv
// 2x2 signed fixed-point matrix multiply, C = A x B, computed in 8 steps on one shared MAC.
// pe: combinational MAC, y_out = low WIDTH bits of ((a_in*b) >>> FRAC_BIT) + y_in, wrapping.
module pe #(
  parameter int WIDTH    = 16,
  parameter int FRAC_BIT = 10
) (
  input  logic signed [WIDTH-1:0] a_in,
  input  logic signed [WIDTH-1:0] b,
  input  logic        [WIDTH-1:0] y_in,
  output logic        [WIDTH-1:0] y_out
);

  logic signed [2*WIDTH-1:0] prod_s;

  assign prod_s = a_in * b;
  assign y_out  = WIDTH'(prod_s >>> FRAC_BIT) + y_in;

endmodule

module pe_matmul2x2_seq #(
  parameter int WIDTH    = 16,
  parameter int FRAC_BIT = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [4*WIDTH-1:0] a_mat,
  input  logic [4*WIDTH-1:0] b_mat,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [4*WIDTH-1:0] c_mat
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [4*WIDTH-1:0] a_q;
  logic [4*WIDTH-1:0] b_q;
  logic [4*WIDTH-1:0] c_q;
  logic [WIDTH-1:0]   acc_q;
  logic [2:0]         step_q;
  logic               done_q;

  logic [1:0]       a_sel_s;
  logic [1:0]       b_sel_s;
  logic [1:0]       c_sel_s;
  logic [WIDTH-1:0] pe_a_s;
  logic [WIDTH-1:0] pe_b_s;
  logic [WIDTH-1:0] pe_y_in_s;
  logic [WIDTH-1:0] pe_y_out_s;

  // step = {i, j, k}: A[i][k], B[k][j], target C[i][j]; k==0 starts a fresh dot product
  always_comb begin
    a_sel_s   = {step_q[2], step_q[0]};
    b_sel_s   = {step_q[0], step_q[1]};
    c_sel_s   = {step_q[2], step_q[1]};
    pe_a_s    = a_q[a_sel_s*WIDTH +: WIDTH];
    pe_b_s    = b_q[b_sel_s*WIDTH +: WIDTH];
    if (step_q[0]) begin
      pe_y_in_s = acc_q;
    end else begin
      pe_y_in_s = {WIDTH{1'b0}};
    end
  end

  pe #(.WIDTH(WIDTH), .FRAC_BIT(FRAC_BIT)) u_pe (
    .a_in  (pe_a_s),
    .b     (pe_b_s),
    .y_in  (pe_y_in_s),
    .y_out (pe_y_out_s)
  );

  // Controller FSM: operand latch, step sequencing, accumulator and result writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= {(4*WIDTH){1'b0}};
      b_q     <= {(4*WIDTH){1'b0}};
      c_q     <= {(4*WIDTH){1'b0}};
      acc_q   <= {WIDTH{1'b0}};
      step_q  <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_q     <= a_mat;
            b_q     <= b_mat;
            step_q  <= 3'd0;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_q  <= pe_y_out_s;
          step_q <= step_q + 3'd1;
          if (step_q[0]) begin
            c_q[c_sel_s*WIDTH +: WIDTH] <= pe_y_out_s;
          end
          if (step_q == 3'd7) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy  = (state_q == S_RUN);
  assign done  = done_q;
  assign c_mat = c_q;

endmodule

// File: tb/tb_pe_matmul2x2_seq.sv
// Self-checking bench for pe_matmul2x2_seq: directed vector table, random vectors, handshake and reset sequences.
module tb_pe_matmul2x2_seq;

  localparam int W = 16;
  localparam int F = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [4*W-1:0] a_mat;
  logic [4*W-1:0] b_mat;
  logic          ready;
  logic          busy;
  logic          done;
  logic [4*W-1:0] c_mat;

  int n_cmp  = 0;
  int n_fail = 0;

  pe_matmul2x2_seq #(.WIDTH(W), .FRAC_BIT(F)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_mat (a_mat),
    .b_mat (b_mat),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .c_mat (c_mat)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [63:0] pack4(input logic [15:0] e00, input logic [15:0] e01,
                                        input logic [15:0] e10, input logic [15:0] e11);
    return {e11, e10, e01, e00};
  endfunction

  // Reference: each C[i][j] is the wrapped sum of floor(A[i][k]*B[k][j] / 2^F) over k
  function automatic logic [63:0] ref_mm(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] c;
    longint      sum;
    longint      p;
    logic [15:0] ae;
    logic [15:0] be;
    c = 64'd0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        sum = 0;
        for (int k = 0; k < 2; k++) begin
          ae  = a[(2*i+k)*16 +: 16];
          be  = b[(2*k+j)*16 +: 16];
          p   = longint'($signed(ae)) * longint'($signed(be));
          sum = sum + (p >>> F);
        end
        c[(2*i+j)*16 +: 16] = sum[15:0];
      end
    end
    return c;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // From a negedge: count posedges until done is seen at a negedge (bounded)
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 30) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  // Start a computation from a negedge with ready=1 and collect result, latency and busy cycles
  task automatic run_mat(input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] c, output int lat, output int busy_n);
    a_mat  = a;
    b_mat  = b;
    start  = 1'b1;
    busy_n = 0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    while (!done && lat < 30) begin
      if (busy) busy_n++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    c = c_mat;
  endtask

  logic [63:0] res;
  logic [63:0] ra;
  logic [63:0] rb;
  int          lat;
  int          bn;
  int          n1;
  int          n2;
  int          dcount;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a_mat = 64'd0;
    b_mat = 64'd0;
    vecs[0] = '{"identity", pack4(16'h0400, 16'h0800, 16'h0C00, 16'h1000),
                pack4(16'h0400, 16'h0000, 16'h0000, 16'h0400),
                pack4(16'h0400, 16'h0800, 16'h0C00, 16'h1000)};
    vecs[1] = '{"signed_mix", pack4(16'h0B00, 16'hF300, 16'h0780, 16'hF600),
                pack4(16'h0500, 16'h0000, 16'h0800, 16'h0000),
                pack4(16'hF3C0, 16'h0000, 16'hF560, 16'h0000)};
    vecs[2] = '{"wrap", pack4(16'h7C00, 16'h0, 16'h0, 16'h0), pack4(16'h0800, 16'h0, 16'h0, 16'h0),
                pack4(16'hF800, 16'h0, 16'h0, 16'h0)};
    vecs[3] = '{"floor_pos", pack4(16'h0001, 16'h0, 16'h0, 16'h0), pack4(16'h0001, 16'h0, 16'h0, 16'h0),
                pack4(16'h0000, 16'h0, 16'h0, 16'h0)};
    vecs[4] = '{"floor_neg", pack4(16'hFFFF, 16'h0, 16'h0, 16'h0), pack4(16'h0001, 16'h0, 16'h0, 16'h0),
                pack4(16'hFFFF, 16'h0, 16'h0, 16'h0)};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_c", c_mat, 64'd0);

    for (int v = 0; v < 5; v++) begin
      run_mat(vecs[v].a, vecs[v].b, res, lat, bn);
      check({vecs[v].name, "_c"}, res, vecs[v].c);
      check({vecs[v].name, "_lat"}, 64'(lat), 64'd9);
      check({vecs[v].name, "_busy"}, 64'(bn), 64'd8);
      @(posedge clk);
      @(negedge clk);
      check({vecs[v].name, "_pulse"}, 64'(done), 64'd0);
      check({vecs[v].name, "_idle"}, 64'(ready), 64'd1);
    end

    for (int r = 0; r < 20; r++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      if (r < 10) begin
        ra = ra & {4{16'h0FFF}};
        rb = rb & {4{16'h0FFF}};
      end
      run_mat(ra, rb, res, lat, bn);
      check("random_c", res, ref_mm(ra, rb));
      check("random_lat", 64'(lat), 64'd9);
    end

    // Back-to-back with operand change mid-RUN
    @(negedge clk);
    a_mat = vecs[1].a;
    b_mat = vecs[1].b;
    start = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    a_mat = vecs[0].a;
    b_mat = vecs[0].b;
    wait_done(n1);
    check("b2b_first_lat", 64'(n1 + 3), 64'd9);
    check("b2b_first_c", c_mat, vecs[1].c);
    ra = pack4(16'h0C00, 16'hFC00, 16'h0200, 16'h0100);
    rb = pack4(16'h0400, 16'h0800, 16'hF800, 16'h0C00);
    a_mat = ra;
    b_mat = rb;
    @(posedge clk);
    @(negedge clk);
    check("b2b_direct_busy", 64'(busy), 64'd1);
    start = 1'b0;
    a_mat = 64'd0;
    wait_done(n2);
    check("b2b_second_lat", 64'(n2 + 1), 64'd9);
    check("b2b_second_c", c_mat, ref_mm(ra, rb));
    @(posedge clk);
    @(negedge clk);
    check("b2b_pulse", 64'(done), 64'd0);

    // Start pulse while busy is ignored
    dcount = 0;
    a_mat = vecs[0].a;
    b_mat = vecs[0].b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a_mat = vecs[1].a;
    b_mat = vecs[1].b;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (25) begin
      if (done) dcount++;
      @(posedge clk);
      @(negedge clk);
    end
    check("busy_start_dones", 64'(dcount), 64'd1);
    check("busy_start_c", c_mat, vecs[0].c);

    // Reset asserted at step 4
    a_mat = vecs[1].a;
    b_mat = vecs[1].b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_ready", 64'(ready), 64'd1);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_c", c_mat, 64'd0);
    dcount = 0;
    repeat (15) begin
      if (done) dcount++;
      @(posedge clk);
      @(negedge clk);
    end
    check("rst_mid_no_done", 64'(dcount), 64'd0);
    run_mat(vecs[1].a, vecs[1].b, res, lat, bn);
    check("rst_after_c", res, vecs[1].c);
    check("rst_after_lat", 64'(lat), 64'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
